ifetch_prefetch_queue: RTL and testbench

Instruction prefetch queue between the instruction-cache memory port and the decoder state register. It owns the fetch PC and issues one word request at a time. Returned words are buffered with their PCs in a small FIFO, and the head entry (or a NOP when empty) is presented to the decoder state register. The FIFO pops only when the memory stage reports the pipeline ready; an execute-stage redirect flushes it.

---
 rtl/ifetch_prefetch_queue.sv | 94 +++++++++
 tb/tb_ifetch_prefetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: instruction prefetch FIFO between the i-cache port and the decoder state register
// Optional feature: define IFQ_BYPASS_EN to present a response word combinationally when the FIFO is empty.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_pipeline_ready            pop permission from the memory stage
//   i_pc_load, i_ext_pc         execute-stage redirect and its target
//   o_valid, o_pc, o_instruction  presented head entry (0 / NOP_INSTR when empty)
//   o_mem_req_valid/_addr, i_mem_req_ready    single outstanding word request
//   i_mem_res_valid, i_mem_res_data           response word
module ifetch_prefetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pipeline_ready,
  input  logic            i_pc_load,
  input  logic [XLEN-1:0] i_ext_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instruction,
  output logic            o_mem_req_valid,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_req_ready,
  input  logic            i_mem_res_valid,
  input  logic [XLEN-1:0] i_mem_res_data
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;
  state_t state;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] ins_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count, count_nxt;
  logic res, byp, push, pop, empty;
  assign res = state == WAIT && i_mem_res_valid;
  assign empty = count == '0;
`ifdef IFQ_BYPASS_EN
  assign byp = res && empty;
`else
  assign byp = 1'b0;
`endif
  // a bypassed word consumed on the same edge never enters the FIFO
  assign push = res && !i_pc_load && !(byp && i_pipeline_ready);
  assign pop = i_pipeline_ready && !empty && !i_pc_load;
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
  assign o_valid = !empty || byp;
  assign o_pc = !empty ? pc_q[rd_ptr] : byp ? req_pc : '0;
  assign o_instruction = !empty ? ins_q[rd_ptr] : byp ? i_mem_res_data : NOP_INSTR;
  // the FSM resets into REQ, so the request is masked while reset is held
  assign o_mem_req_valid = i_reset && state == REQ;
  assign o_mem_req_addr = fetch_pc;
  always_ff @(posedge i_clk)
    if (push) begin
      pc_q[wr_ptr] <= req_pc;
      ins_q[wr_ptr] <= i_mem_res_data;
    end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state <= REQ;
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (i_pc_load) begin
      fetch_pc <= {i_ext_pc[XLEN-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      // any request still in flight after this edge must have its response swallowed
      state <= ((state == WAIT || state == FLUSH) && !i_mem_res_valid) || (state == REQ && i_mem_req_ready) ? FLUSH : REQ;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      case (state)
        IDLE: if (count < FULL) state <= REQ;
        REQ: if (i_mem_req_ready) begin
          state <= WAIT;
          req_pc <= fetch_pc;
        end
        WAIT: if (i_mem_res_valid) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          state <= count_nxt < FULL ? REQ : IDLE;
        end
        FLUSH: if (i_mem_res_valid) state <= REQ;
      endcase
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb_ifetch_prefetch_queue: scoreboard bench with a one-outstanding memory model returning addr+0x100
module tb_ifetch_prefetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic i_clk = 0, i_reset = 0, i_pipeline_ready = 0, i_pc_load = 0;
  logic [31:0] i_ext_pc = '0;
  logic o_valid, o_mem_req_valid;
  logic [31:0] o_pc, o_instruction, o_mem_req_addr;
  logic i_mem_req_ready = 1, i_mem_res_valid = 0;
  logic [31:0] i_mem_res_data = '0;
  ifetch_prefetch_queue dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pipeline_ready(i_pipeline_ready),
    .i_pc_load(i_pc_load), .i_ext_pc(i_ext_pc), .o_valid(o_valid), .o_pc(o_pc),
    .o_instruction(o_instruction), .o_mem_req_valid(o_mem_req_valid),
    .o_mem_req_addr(o_mem_req_addr), .i_mem_req_ready(i_mem_req_ready),
    .i_mem_res_valid(i_mem_res_valid), .i_mem_res_data(i_mem_res_data)
  );
  always #5 i_clk = ~i_clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];
  int vectors = 0, miscompares = 0;
  int n_acc = 0, n_live = 0, pops = 0, pend_wait = 0, res_delay = 0;
  bit pend = 0, stale = 0, v_pre = 0;
  logic [31:0] pend_pc = '0, exp_req = '0, last_a = '0, last_pop_pc = '0;
  // one clock cycle: drive memory response, sample, update scoreboard, cross the edge
  task automatic step();
    bit acc, resp;
    logic [31:0] a;
    i_mem_res_valid = pend && pend_wait == 0;
    i_mem_res_data = pend_pc + 32'h100;
    #1;
    acc = o_mem_req_valid && i_mem_req_ready;
    a = o_mem_req_addr;
    resp = i_mem_res_valid;
    v_pre = o_valid;
    if (acc) begin
      vectors++;
      if (a !== exp_req || pend) begin
        miscompares++;
        $display("FAIL req_addr: got %h want %h outstanding=%0d", a, exp_req, pend);
      end
    end
    if (resp && !stale && !i_pc_load) begin
      q_pc.push_back(pend_pc);
      q_in.push_back(pend_pc + 32'h100);
      exp_req = exp_req + 32'd4;
    end
    if (o_valid && !i_pc_load) begin
      vectors++;
      if (q_pc.size() == 0) begin
        miscompares++;
        $display("FAIL head: got valid pc=%h instr=%h want nothing valid", o_pc, o_instruction);
      end else begin
        if (o_pc !== q_pc[0] || o_instruction !== q_in[0]) begin
          miscompares++;
          $display("FAIL head: got pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instruction, q_pc[0], q_in[0]);
        end
        if (i_pipeline_ready) begin
          last_pop_pc = q_pc.pop_front();
          void'(q_in.pop_front());
          pops++;
        end
      end
    end else if (!o_valid) begin
      vectors++;
      if (o_pc !== 32'h0 || o_instruction !== NOP) begin
        miscompares++;
        $display("FAIL empty_out: got pc=%h instr=%h want pc=0 instr=%h", o_pc, o_instruction, NOP);
      end
    end
    if (i_pc_load) begin
      q_pc.delete();
      q_in.delete();
      exp_req = {i_ext_pc[31:2], 2'b00};
      if (pend) stale = 1;
    end
    @(posedge i_clk);
    if (resp) pend = 0;
    else if (pend && pend_wait > 0) pend_wait--;
    if (acc) begin
      pend = 1;
      pend_pc = a;
      pend_wait = res_delay;
      stale = i_pc_load;
      n_acc++;
      if (!i_pc_load) n_live++;
      last_a = a;
    end
    @(negedge i_clk);
  endtask
  task automatic redirect(input logic [31:0] t);
    i_pc_load = 1;
    i_ext_pc = t;
    step();
    i_pc_load = 0;
  endtask
  task automatic test_reset();
    i_reset = 0;
    repeat (2) @(negedge i_clk);
    #1;
    vectors++;
    if (o_valid !== 0 || o_pc !== 0 || o_instruction !== NOP || o_mem_req_valid !== 0 || o_mem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b pc=%h ins=%h rv=%b ra=%h want 0 0 %h 0 0", o_valid, o_pc, o_instruction, o_mem_req_valid, o_mem_req_addr, NOP);
    end
    @(negedge i_clk);
    i_reset = 1;
    pend = 0; stale = 0; exp_req = 32'h0;
    q_pc.delete(); q_in.delete();
    #1;
    vectors++;
    if (o_mem_req_valid !== 1 || o_mem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_req: got valid=%b addr=%h want 1 00000000", o_mem_req_valid, o_mem_req_addr);
    end
  endtask
  task automatic test_stream();
    int p0 = pops;
    i_pipeline_ready = 1;
    repeat (20) step();
    vectors++;
    if (pops - p0 < 8) begin
      miscompares++;
      $display("FAIL stream_rate: got %0d pops in 20 cycles want >=8", pops - p0);
    end
  endtask
  task automatic test_fill();
    int n0;
    i_pipeline_ready = 0;
    redirect(32'h40);
    n0 = n_live;
    repeat (16) step();
    #1;
    vectors++;
    if (n_live - n0 != 4 || o_mem_req_valid !== 0 || o_valid !== 1 || q_pc.size() != 4) begin
      miscompares++;
      $display("FAIL fill: got reqs=%0d rv=%b v=%b want reqs=4 rv=0 v=1", n_live - n0, o_mem_req_valid, o_valid);
    end
    i_pipeline_ready = 1;
    step();
    i_pipeline_ready = 0;
    repeat (6) step();
    vectors++;
    if (n_live - n0 != 5 || last_a !== 32'h50) begin
      miscompares++;
      $display("FAIL refill: got reqs=%0d last=%h want 5 00000050", n_live - n0, last_a);
    end
  endtask
  task automatic test_redirect_wait();
    bit hit = 0;
    i_pipeline_ready = 1;
    res_delay = 3;
    for (int i = 0; i < 30 && !(pend && pend_wait > 0 && !stale); i++) step();
    redirect(32'h2002);
    for (int i = 0; i < 30; i++) begin
      step();
      if (v_pre) begin
        hit = 1;
        break;
      end
    end
    vectors++;
    if (!hit || last_pop_pc !== 32'h2000) begin
      miscompares++;
      $display("FAIL redirect_wait: got seen=%0d pc=%h want 1 00002000", hit, last_pop_pc);
    end
    res_delay = 0;
  endtask
  task automatic test_redirect_pushpop();
    int n0;
    i_pipeline_ready = 0;
    redirect(32'h100);
    for (int i = 0; i < 40 && !(q_pc.size() == 2 && pend && pend_wait == 0 && !stale); i++) step();
    vectors++;
    if (q_pc.size() != 2) begin
      miscompares++;
      $display("FAIL pushpop_setup: got count=%0d want 2", q_pc.size());
    end
    i_pipeline_ready = 1;
    i_pc_load = 1;
    i_ext_pc = 32'h3000;
    step();
    i_pc_load = 0;
    i_pipeline_ready = 0;
    #1;
    vectors++;
    if (o_valid !== 0) begin
      miscompares++;
      $display("FAIL pushpop_flush: got valid=%b pc=%h want 0", o_valid, o_pc);
    end
    n0 = n_acc;
    for (int i = 0; i < 5 && n_acc == n0; i++) step();
    vectors++;
    if (n_acc == n0 || last_a !== 32'h3000) begin
      miscompares++;
      $display("FAIL pushpop_next: got %h want 00003000", last_a);
    end
    i_pipeline_ready = 1;
    repeat (6) step();
  endtask
  task automatic test_req_stall();
    int n0;
    logic [31:0] a0;
    i_mem_req_ready = 0;
    repeat (4) step();
    #1;
    a0 = o_mem_req_addr;
    n0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      vectors++;
      if (o_mem_req_valid !== 1 || o_mem_req_addr !== a0) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%b addr=%h want 1 %h", o_mem_req_valid, o_mem_req_addr, a0);
      end
    end
    i_mem_req_ready = 1;
    step();
    vectors++;
    if (n_acc - n0 != 1 || last_a !== a0) begin
      miscompares++;
      $display("FAIL stall_once: got reqs=%0d addr=%h want 1 %h", n_acc - n0, last_a, a0);
    end
    repeat (4) step();
  endtask
  task automatic test_bypass();
    i_pipeline_ready = 0;
    redirect(32'h5000);
    for (int i = 0; i < 20 && !(pend && pend_wait == 0 && !stale); i++) step();
    i_pipeline_ready = 1;
    step();
    #1;
    vectors++;
`ifdef IFQ_BYPASS_EN
    if (v_pre !== 1 || o_valid !== 0 || q_pc.size() != 0 || last_pop_pc !== 32'h5000) begin
      miscompares++;
      $display("FAIL bypass: got same_cycle=%b after=%b pc=%h want 1 0 00005000", v_pre, o_valid, last_pop_pc);
    end
`else
    if (v_pre !== 0 || o_valid !== 1 || o_pc !== 32'h5000) begin
      miscompares++;
      $display("FAIL no_bypass: got same_cycle=%b next=%b pc=%h want 0 1 00005000", v_pre, o_valid, o_pc);
    end
`endif
    repeat (4) step();
  endtask
  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_wait();
    test_redirect_pushpop();
    test_req_stall();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
